// File: rtl/ex_mem_skid_pipe.sv
// rtl/ex_mem_skid_pipe.sv - EX/MEM pipeline register with two-entry skid buffer, flush and optional perf counters
// Optional feature macro: EX_MEM_PERF_CNT_EN (implements perf_* counters; otherwise they are tied to 0)
module ex_mem_skid_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_alu_result,
  input  logic [DATA_WIDTH-1:0]     in_write_data,
  input  logic [ADDR_WIDTH-1:0]     in_daddr,
  input  logic                      in_mem_write,
  input  logic                      in_mem_read,
  input  logic [2:0]                in_funct3,
  input  logic [REG_ADDR_WIDTH-1:0] in_reg_dest,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_alu_result,
  output logic [DATA_WIDTH-1:0]     out_write_data,
  output logic [ADDR_WIDTH-1:0]     out_daddr,
  output logic                      out_mem_write,
  output logic                      out_mem_read,
  output logic [2:0]                out_funct3,
  output logic [REG_ADDR_WIDTH-1:0] out_reg_dest,
  output logic [CNT_WIDTH-1:0]      perf_stall_cycles,
  output logic [CNT_WIDTH-1:0]      perf_bubble_cycles,
  output logic [CNT_WIDTH-1:0]      perf_flush_count
);

  // Data fields survive a flush; control fields are zeroed by it, so keep them apart.
  localparam int DATA_W = 2 * DATA_WIDTH + ADDR_WIDTH;
  localparam int CTRL_W = 5 + REG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e            state_q;
  logic              main_vld_q;
  logic              skid_vld_q;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              accept;
  logic              rel;
  logic              head_mem_write;
  logic              head_mem_read;

  assign in_data = {in_alu_result, in_write_data, in_daddr};
  assign in_ctrl = {in_mem_write, in_mem_read, in_funct3, in_reg_dest};

  // in_ready is a flop, so accept never depends combinationally on out_ready.
  assign accept = in_valid & in_ready_q;
  assign rel    = main_vld_q & out_ready;

  // Buffer FSM: the main entry is the FIFO head, the skid entry absorbs one beat under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      skid_data_q <= '0;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush) begin
      state_q     <= S_EMPTY;
      main_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
            main_vld_q  <= 1'b1;
            state_q     <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && rel) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
          end else if (accept) begin
            skid_data_q <= in_data;
            skid_ctrl_q <= in_ctrl;
            skid_vld_q  <= 1'b1;
            in_ready_q  <= 1'b0;
            state_q     <= S_FULL;
          end else if (rel) begin
            main_vld_q  <= 1'b0;
            state_q     <= S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a release can move the buffer.
          if (rel) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
            main_vld_q  <= skid_vld_q;
            skid_vld_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_ONE;
          end
        end
        default: begin
          main_vld_q <= 1'b0;
          skid_vld_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= S_EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;

  assign {out_alu_result, out_write_data, out_daddr}                = main_data_q;
  assign {head_mem_write, head_mem_read, out_funct3, out_reg_dest} = main_ctrl_q;

  // An invalid head must never start a memory access.
  assign out_mem_write = head_mem_write & main_vld_q;
  assign out_mem_read  = head_mem_read & main_vld_q;

`ifdef EX_MEM_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] stall_q;
  logic [CNT_WIDTH-1:0] bubble_q;
  logic [CNT_WIDTH-1:0] flush_q;

  // Saturating event counters; only rst clears them, flush is itself an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (main_vld_q && !out_ready && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (!main_vld_q && (bubble_q != CNT_MAX)) begin
        bubble_q <= bubble_q + CNT_ONE;
      end
      if (flush && (flush_q != CNT_MAX)) begin
        flush_q <= flush_q + CNT_ONE;
      end
    end
  end

  assign perf_stall_cycles  = stall_q;
  assign perf_bubble_cycles = bubble_q;
  assign perf_flush_count   = flush_q;
`else
  assign perf_stall_cycles  = '0;
  assign perf_bubble_cycles = '0;
  assign perf_flush_count   = '0;
`endif

endmodule

// File: tb/tb_ex_mem_skid_pipe.sv
// tb/tb_ex_mem_skid_pipe.sv - self-checking bench for ex_mem_skid_pipe
module tb_ex_mem_skid_pipe;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] wd;
    logic [AW-1:0] da;
    logic          mw;
    logic          mr;
    logic [2:0]    f3;
    logic [RW-1:0] rd;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_alu_result;
  logic [DW-1:0] in_write_data;
  logic [AW-1:0] in_daddr;
  logic          in_mem_write;
  logic          in_mem_read;
  logic [2:0]    in_funct3;
  logic [RW-1:0] in_reg_dest;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_alu_result;
  logic [DW-1:0] out_write_data;
  logic [AW-1:0] out_daddr;
  logic          out_mem_write;
  logic          out_mem_read;
  logic [2:0]    out_funct3;
  logic [RW-1:0] out_reg_dest;
  logic [CW-1:0] perf_stall_cycles;
  logic [CW-1:0] perf_bubble_cycles;
  logic [CW-1:0] perf_flush_count;

  int errors = 0;
  int checks = 0;
  bit live = 1'b0;

  always #5 clk = ~clk;

  ex_mem_skid_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_write_data(in_write_data), .in_daddr(in_daddr),
    .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
    .in_funct3(in_funct3), .in_reg_dest(in_reg_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_write_data(out_write_data), .out_daddr(out_daddr),
    .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
    .out_funct3(out_funct3), .out_reg_dest(out_reg_dest),
    .perf_stall_cycles(perf_stall_cycles), .perf_bubble_cycles(perf_bubble_cycles),
    .perf_flush_count(perf_flush_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic beat_t mk(input int unsigned n, input logic mw, input logic mr);
    beat_t b;
    b.alu = n;
    b.wd  = n * 16 + 1;
    b.da  = 32'h1000 + n * 4;
    b.mw  = mw;
    b.mr  = mr;
    b.f3  = 3'(n);
    b.rd  = RW'(n + 1);
    return b;
  endfunction

  task automatic drive(input logic v, input beat_t b);
    in_valid      = v;
    in_alu_result = b.alu;
    in_write_data = b.wd;
    in_daddr      = b.da;
    in_mem_write  = b.mw;
    in_mem_read   = b.mr;
    in_funct3     = b.f3;
    in_reg_dest   = b.rd;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: a depth-2 FIFO plus saturating event counts.
  beat_t       mq[$];
  beat_t       m_in;
  bit          m_acc;
  bit          m_rel;
  int unsigned m_stall = 0;
  int unsigned m_bubble = 0;
  int unsigned m_flush = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_stall  = 0;
      m_bubble = 0;
      m_flush  = 0;
    end else begin
      if (mq.size() != 0 && !out_ready && m_stall < CMAX) m_stall++;
      if (mq.size() == 0 && m_bubble < CMAX) m_bubble++;
      if (flush && m_flush < CMAX) m_flush++;
      m_acc = in_valid && (mq.size() < 2);
      m_rel = (mq.size() != 0) && out_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_rel) void'(mq.pop_front());
        if (m_acc) begin
          m_in.alu = in_alu_result;
          m_in.wd  = in_write_data;
          m_in.da  = in_daddr;
          m_in.mw  = in_mem_write;
          m_in.mr  = in_mem_read;
          m_in.f3  = in_funct3;
          m_in.rd  = in_reg_dest;
          mq.push_back(m_in);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("out_valid", out_valid, mq.size() != 0);
      chk("in_ready", in_ready, mq.size() < 2);
      if (mq.size() != 0) begin
        chk("head_alu", out_alu_result, mq[0].alu);
        chk("head_wdata", out_write_data, mq[0].wd);
        chk("head_daddr", out_daddr, mq[0].da);
        chk("head_mem_write", out_mem_write, mq[0].mw);
        chk("head_mem_read", out_mem_read, mq[0].mr);
        chk("head_funct3", out_funct3, mq[0].f3);
        chk("head_reg_dest", out_reg_dest, mq[0].rd);
      end else begin
        chk("gated_mem_write", out_mem_write, 1'b0);
        chk("gated_mem_read", out_mem_read, 1'b0);
      end
`ifdef EX_MEM_PERF_CNT_EN
      chk("perf_stall", perf_stall_cycles, m_stall);
      chk("perf_bubble", perf_bubble_cycles, m_bubble);
      chk("perf_flush", perf_flush_count, m_flush);
`else
      chk("perf_stall_tied", perf_stall_cycles, 0);
      chk("perf_bubble_tied", perf_bubble_cycles, 0);
      chk("perf_flush_tied", perf_flush_count, 0);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned got[$];
    int first_c;

    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    live = 1'b1;

    // Reset state.
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu", out_alu_result, 0);
    chk("rst_reg_dest", out_reg_dest, 0);
    chk("rst_perf_stall", perf_stall_cycles, 0);

    // Streaming: 8 beats back to back, one out per cycle, latency one edge.
    out_ready = 1'b1;
    first_c = -1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) begin
        got.push_back(out_alu_result);
        if (first_c < 0) first_c = c;
      end
      chk("stream_in_ready", in_ready, 1);
      if (c < 8) drive(1'b1, mk(c + 1, 1'(c), 1'(~c)));
      else in_valid = 1'b0;
      tick();
    end
    chk("stream_first_cycle", first_c, 1);
    chk("stream_count", got.size(), 8);
    for (int k = 0; k < 8 && k < got.size(); k++) chk("stream_order", got[k], k + 1);

    // Backpressure: two beats absorbed, third held at the input.
    out_ready = 1'b0;
    drive(1'b1, mk(1, 0, 0));
    tick();
    chk("bp_head1", out_alu_result, 1);
    chk("bp_ready_one", in_ready, 1);
    drive(1'b1, mk(2, 0, 0));
    tick();
    chk("bp_ready_full", in_ready, 0);
    drive(1'b1, mk(3, 0, 0));
    tick();
    tick();
    chk("bp_hold_head", out_alu_result, 1);
    chk("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("bp_drain2", out_alu_result, 2);
    chk("bp_ready_rise", in_ready, 1);
    tick();
    chk("bp_drain3", out_alu_result, 3);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", out_valid, 0);

    // Flush while FULL with a store offered.
    out_ready = 1'b0;
    drive(1'b1, mk(10, 0, 0));
    tick();
    drive(1'b1, mk(11, 0, 0));
    tick();
    chk("fl_full", in_ready, 0);
    drive(1'b1, mk(12, 1, 0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_mem_write", out_mem_write, 0);
    chk("fl_reg_dest", out_reg_dest, 0);
    chk("fl_funct3", out_funct3, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_data_held", out_alu_result, 10);
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("fl_no_ghost", out_valid, 0);
    end

    // Gating: load at the head, then flushed away.
    out_ready = 1'b0;
    drive(1'b1, mk(20, 0, 1));
    tick();
    in_valid = 1'b0;
    chk("gate_mr_on", out_mem_read, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("gate_valid_off", out_valid, 0);
    chk("gate_mr_off", out_mem_read, 0);
    out_ready = 1'b1;
    drive(1'b1, mk(21, 1, 0));
    tick();
    in_valid = 1'b0;
    chk("gate_mw_on", out_mem_write, 1);
    tick();
    chk("gate_mw_released", out_mem_write, 0);

    // rst while FULL, with every other control active.
    out_ready = 1'b0;
    drive(1'b1, mk(30, 1, 1));
    tick();
    drive(1'b1, mk(31, 1, 1));
    tick();
    rst = 1'b1;
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, mk(32, 1, 1));
    tick();
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_alu", out_alu_result, 0);
    chk("mrst_wdata", out_write_data, 0);
    chk("mrst_daddr", out_daddr, 0);
    chk("mrst_mw", out_mem_write, 0);
    chk("mrst_mr", out_mem_read, 0);
    chk("mrst_funct3", out_funct3, 0);
    chk("mrst_reg_dest", out_reg_dest, 0);
    chk("mrst_stall", perf_stall_cycles, 0);
    chk("mrst_bubble", perf_bubble_cycles, 0);
    chk("mrst_flush", perf_flush_count, 0);

    // Stall counter saturation: one bubble cycle, then 20 stall cycles.
    drive(1'b1, mk(40, 0, 0));
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
`ifdef EX_MEM_PERF_CNT_EN
    chk("sat_stall", perf_stall_cycles, 15);
    chk("sat_bubble", perf_bubble_cycles, 1);
`else
    chk("sat_stall", perf_stall_cycles, 0);
    chk("sat_bubble", perf_bubble_cycles, 0);
`endif
    chk("sat_flush", perf_flush_count, 0);

    out_ready = 1'b1;
    tick();
    tick();
    live = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
